// File: rtl/frame_stream_arbiter.sv
// Round-robin, frame-atomic arbiter that merges NUM_SRC AXI-Stream sources onto one path; 1-cycle arbitration,
// data passes combinationally while ACTIVE; M_AXIS_tready mirrors to the owner only; runaway frames are cut and drained.
module frame_stream_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  S_AXIS_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0]  S_AXIS_tkeep,
  input  logic [NUM_SRC-1:0]             S_AXIS_tvalid,
  input  logic [NUM_SRC-1:0]             S_AXIS_tlast,
  output logic [NUM_SRC-1:0]             S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic [KEEP_WIDTH-1:0]          M_AXIS_tkeep,
  output logic                           M_AXIS_tvalid,
  output logic                           M_AXIS_tlast,
  input  logic                           M_AXIS_tready,
  input  logic [NUM_SRC-1:0]             Src_Enable,
  output logic [NUM_SRC-1:0]             Grant,
  output logic                           Truncated,
  output logic [1:0]                     Arb_State
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // One-hot grant selects the owner's beat with an AND-OR mux.
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_vld;
  logic                  sel_last;

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data = sel_data | ({DATA_WIDTH{grant_q[i]}} & S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH]);
      sel_keep = sel_keep | ({KEEP_WIDTH{grant_q[i]}} & S_AXIS_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]);
      sel_vld  = sel_vld  | (grant_q[i] & S_AXIS_tvalid[i]);
      sel_last = sel_last | (grant_q[i] & S_AXIS_tlast[i]);
    end
  end

  // Rotate candidates so bit 0 is last_grant+1, take the lowest set bit, then map back.
  logic [NUM_SRC-1:0]   cand;
  logic [2*NUM_SRC-1:0] cand2;
  logic [NUM_SRC-1:0]   rot;
  logic [IDX_W:0]       start;
  logic [IDX_W+1:0]     win_sum;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_SRC-1:0]   win_oh;

  always_comb begin
    cand    = S_AXIS_tvalid & Src_Enable;
    cand2   = {cand, cand};
    start   = {1'b0, last_q} + 1'b1;
    rot     = cand2[start +: NUM_SRC];
    win_vld = 1'b0;
    win_sum = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win_vld = 1'b1;
        win_sum = (IDX_W+2)'(j) + (IDX_W+2)'(start);
      end
    end
    if (win_sum >= (IDX_W+2)'(NUM_SRC)) win_sum = win_sum - (IDX_W+2)'(NUM_SRC);
    win_idx = win_sum[IDX_W-1:0];
    for (int i = 0; i < NUM_SRC; i++) win_oh[i] = (win_idx == IDX_W'(i));
  end

  logic force_last;
  assign force_last = (cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    trunc_d       = 1'b0;
    S_AXIS_tready = '0;
    M_AXIS_tdata  = '0;
    M_AXIS_tkeep  = '0;
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ACTIVE;
          grant_d = win_oh;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        M_AXIS_tdata  = sel_data;
        M_AXIS_tkeep  = sel_keep;
        M_AXIS_tvalid = sel_vld;
        M_AXIS_tlast  = sel_last | force_last;
        S_AXIS_tready = grant_q & {NUM_SRC{M_AXIS_tready}};
        if (sel_vld && M_AXIS_tready) begin
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = IDLE;
            grant_d = '0;
          end else if (force_last) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Tail of a truncated frame is swallowed without reaching the frame former.
        S_AXIS_tready = grant_q;
        if (sel_vld && sel_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign Grant     = grant_q;
  assign Truncated = trunc_q;
  assign Arb_State = state_q;

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed bench for frame_stream_arbiter: per-cycle vector table plus a mid-frame reset sequence.
module tb_frame_stream_arbiter;

  localparam int NS = 2;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MB = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS-1:0]     s_tvalid, s_tlast, s_tready, src_en, grant;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tready, truncated;
  logic [1:0]        arb_state;

  frame_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(s_tvalid),
    .S_AXIS_tlast(s_tlast), .S_AXIS_tready(s_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tkeep(m_tkeep), .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tlast(m_tlast), .M_AXIS_tready(m_tready),
    .Src_Enable(src_en), .Grant(grant), .Truncated(truncated), .Arb_State(arb_state)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0] v, l, en;
    logic       r;
    logic [7:0] t0, t1;
    logic [1:0] srdy;
    logic       mvld, mlast;
    logic [7:0] tag;
    logic [1:0] gnt, st;
    logic       tr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] v, input logic [1:0] l, input logic [1:0] en, input logic r,
                     input logic [7:0] t0, input logic [7:0] t1,
                     input logic [1:0] srdy, input logic mvld, input logic mlast, input logic [7:0] tag,
                     input logic [1:0] gnt, input logic [1:0] st, input logic tr);
    vec_t x;
    x.v = v; x.l = l; x.en = en; x.r = r; x.t0 = t0; x.t1 = t1;
    x.srdy = srdy; x.mvld = mvld; x.mlast = mlast; x.tag = tag;
    x.gnt = gnt; x.st = st; x.tr = tr;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [1:0] en, input logic r,
                       input logic [7:0] t0, input logic [7:0] t1);
    s_tvalid = v;
    s_tlast  = l;
    src_en   = en;
    m_tready = r;
    s_tdata  = {{8{t1}}, {8{t0}}};
    s_tkeep  = {t1, t0};
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, ".m_tlast"},  64'(m_tlast),  64'd0);
    chk({tag, ".m_tdata"},  m_tdata,       64'd0);
    chk({tag, ".m_tkeep"},  64'(m_tkeep),  64'd0);
    chk({tag, ".s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, ".grant"},    64'(grant),    64'd0);
    chk({tag, ".state"},    64'(arb_state), 64'd0);
    chk({tag, ".trunc"},    64'(truncated), 64'd0);
  endtask

  initial begin
    // Single source 0, 4-beat frame (tlast coincides with the watchdog limit: no truncation)
    add(2'b01,2'b00,2'b11,1,8'hA1,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b01,2'b00,2'b11,1,8'hA1,8'h00, 2'b01,1,0,8'hA1, 2'b01,2'd1,0);
    add(2'b01,2'b00,2'b11,1,8'hA2,8'h00, 2'b01,1,0,8'hA2, 2'b01,2'd1,0);
    add(2'b01,2'b00,2'b11,1,8'hA3,8'h00, 2'b01,1,0,8'hA3, 2'b01,2'd1,0);
    add(2'b01,2'b01,2'b11,1,8'hA4,8'h00, 2'b01,1,1,8'hA4, 2'b01,2'd1,0);
    add(2'b00,2'b00,2'b11,1,8'h00,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    // Both request 2-beat frames; last owner was 0 so order is 1,0,1
    add(2'b11,2'b00,2'b11,1,8'hB1,8'hC1, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b11,1,8'hB1,8'hC1, 2'b10,1,0,8'hC1, 2'b10,2'd1,0);
    add(2'b11,2'b10,2'b11,1,8'hB1,8'hC2, 2'b10,1,1,8'hC2, 2'b10,2'd1,0);
    add(2'b11,2'b00,2'b11,1,8'hB1,8'hC3, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b11,1,8'hB1,8'hC3, 2'b01,1,0,8'hB1, 2'b01,2'd1,0);
    add(2'b11,2'b01,2'b11,1,8'hB2,8'hC3, 2'b01,1,1,8'hB2, 2'b01,2'd1,0);
    add(2'b11,2'b00,2'b11,1,8'hB3,8'hC3, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b11,1,8'hB3,8'hC3, 2'b10,1,0,8'hC3, 2'b10,2'd1,0);
    add(2'b11,2'b10,2'b11,1,8'hB3,8'hC4, 2'b10,1,1,8'hC4, 2'b10,2'd1,0);
    add(2'b00,2'b00,2'b11,1,8'h00,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    // Backpressure during a 3-beat frame from source 0
    add(2'b01,2'b00,2'b11,1,8'hD1,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b01,2'b00,2'b11,1,8'hD1,8'h00, 2'b01,1,0,8'hD1, 2'b01,2'd1,0);
    add(2'b01,2'b00,2'b11,0,8'hD2,8'h00, 2'b00,1,0,8'hD2, 2'b01,2'd1,0);
    add(2'b01,2'b00,2'b11,0,8'hD2,8'h00, 2'b00,1,0,8'hD2, 2'b01,2'd1,0);
    add(2'b01,2'b00,2'b11,1,8'hD2,8'h00, 2'b01,1,0,8'hD2, 2'b01,2'd1,0);
    add(2'b01,2'b01,2'b11,1,8'hD3,8'h00, 2'b01,1,1,8'hD3, 2'b01,2'd1,0);
    add(2'b00,2'b00,2'b11,1,8'h00,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    // Source 1 sends 6 beats with MAX_BEATS=4: truncate, then drain with M ready low
    add(2'b10,2'b00,2'b11,1,8'h00,8'hE1, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b10,2'b00,2'b11,1,8'h00,8'hE1, 2'b10,1,0,8'hE1, 2'b10,2'd1,0);
    add(2'b10,2'b00,2'b11,1,8'h00,8'hE2, 2'b10,1,0,8'hE2, 2'b10,2'd1,0);
    add(2'b10,2'b00,2'b11,1,8'h00,8'hE3, 2'b10,1,0,8'hE3, 2'b10,2'd1,0);
    add(2'b10,2'b00,2'b11,1,8'h00,8'hE4, 2'b10,1,1,8'hE4, 2'b10,2'd1,0);
    add(2'b10,2'b00,2'b11,0,8'h00,8'hE5, 2'b10,0,0,8'h00, 2'b10,2'd2,1);
    add(2'b10,2'b10,2'b11,0,8'h00,8'hE6, 2'b10,0,0,8'h00, 2'b10,2'd2,0);
    add(2'b00,2'b00,2'b11,1,8'h00,8'h00, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    // Src_Enable=10 masks source 0; clearing enable mid-frame does not cut the frame
    add(2'b11,2'b00,2'b10,1,8'hF1,8'h91, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b00,1,8'hF1,8'h91, 2'b10,1,0,8'h91, 2'b10,2'd1,0);
    add(2'b11,2'b10,2'b00,1,8'hF1,8'h92, 2'b10,1,1,8'h92, 2'b10,2'd1,0);
    add(2'b11,2'b00,2'b00,1,8'hF1,8'h93, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b11,1,8'hF1,8'h93, 2'b00,0,0,8'h00, 2'b00,2'd0,0);
    add(2'b11,2'b00,2'b11,1,8'hF1,8'h93, 2'b01,1,0,8'hF1, 2'b01,2'd1,0);

    // Reset with traffic present: outputs must stay quiet
    ARESETN = 1'b0;
    drive(2'b11, 2'b00, 2'b11, 1'b1, 8'h55, 8'h66);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #1 chk_quiet("reset");
    drive(2'b00, 2'b00, 2'b11, 1'b1, 8'h00, 8'h00);
    ARESETN = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge ACLK);
      drive(vecs[k].v, vecs[k].l, vecs[k].en, vecs[k].r, vecs[k].t0, vecs[k].t1);
      #1;
      chk($sformatf("row%0d.s_tready", k), 64'(s_tready),  64'(vecs[k].srdy));
      chk($sformatf("row%0d.m_tvalid", k), 64'(m_tvalid),  64'(vecs[k].mvld));
      chk($sformatf("row%0d.grant", k),    64'(grant),     64'(vecs[k].gnt));
      chk($sformatf("row%0d.state", k),    64'(arb_state), 64'(vecs[k].st));
      chk($sformatf("row%0d.trunc", k),    64'(truncated), 64'(vecs[k].tr));
      if (vecs[k].mvld) begin
        chk($sformatf("row%0d.m_tlast", k), 64'(m_tlast), 64'(vecs[k].mlast));
        chk($sformatf("row%0d.m_tdata", k), m_tdata,      {8{vecs[k].tag}});
        chk($sformatf("row%0d.m_tkeep", k), 64'(m_tkeep), 64'(vecs[k].tag));
      end
    end

    // Mid-frame reset: source 0 owns the path, beat 2 is on the bus
    @(negedge ACLK);
    drive(2'b01, 2'b00, 2'b11, 1'b1, 8'hF2, 8'h93);
    #1 chk("midrst.beat2", m_tdata, {8{8'hF2}});
    ARESETN = 1'b0;
    #1 chk_quiet("midrst.async");
    @(posedge ACLK);
    @(negedge ACLK);
    drive(2'b11, 2'b00, 2'b11, 1'b1, 8'hF3, 8'h93);
    #1 chk_quiet("midrst.held");
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    chk("postrst.grant", 64'(grant), 64'h1);
    chk("postrst.state", 64'(arb_state), 64'd1);
    chk("postrst.m_tdata", m_tdata, {8{8'hF3}});
    chk("postrst.s_tready", 64'(s_tready), 64'h1);
    chk("postrst.m_tlast", 64'(m_tlast), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
